vga_pixel_fetch: RTL and testbench

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pixel_fetch.sv | 213 +++++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_pixel_fetch                                                |
// | Purpose  : Streams an RGB332 framebuffer out as a pixel stream. 32-bit    |
// |            words are read from memory into a 4-deep word FIFO and sent    |
// |            out one byte at a time, low byte first, under a                |
// |            valid/ready handshake. Line and frame end markers are produced |
// |            with each pixel.                                               |
// | Ports    : CLOCK_50     - sole clock, rising edge                         |
// |            resetn       - synchronous reset, active low                   |
// |            frame_start  - one-cycle pulse, restarts the fetch at FB_BASE  |
// |            mem_addr     - byte address to the framebuffer read port       |
// |            mem_rdata    - read data, valid one cycle after mem_addr       |
// |            pix_ready    - consumer takes the pixel this cycle             |
// |            pix_valid    - pix_data/pix_eol/pix_eof hold a pixel           |
// |            pix_data     - RGB332 pixel                                    |
// |            pix_eol      - pixel is the last of its line                   |
// |            pix_eof      - pixel is the last of the frame                  |
// |            underflow    - sticky: consumer was starved mid-frame          |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module vga_pixel_fetch #(
   parameter int          H_RES   = 160,
   parameter int          V_RES   = 120,
   parameter logic [31:0] FB_BASE = 32'h0000_1000
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        frame_start,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        pix_ready,
   output logic        pix_valid,
   output logic [7:0]  pix_data,
   output logic        pix_eol,
   output logic        pix_eof,
   output logic        underflow
);

   localparam int c_WORDS = (H_RES * V_RES) / 4;
   localparam int c_XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int c_YW    = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int c_WW    = $clog2(c_WORDS + 1);

   localparam logic [c_XW-1:0] c_X_LAST = c_XW'(H_RES - 1);
   localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(V_RES - 1);
   localparam logic [c_WW-1:0] c_W_LAST = c_WW'(c_WORDS - 1);
   localparam logic [c_XW-1:0] c_X_ONE  = c_XW'(1);
   localparam logic [c_YW-1:0] c_Y_ONE  = c_YW'(1);
   localparam logic [c_WW-1:0] c_W_ONE  = c_WW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [31:0]     r_addr;
   logic [c_WW-1:0] r_word_cnt;     // words issued so far this frame
   logic            r_inflight;     // a read was issued last cycle
   logic [31:0]     r_fifo [4];
   logic [1:0]      r_wr_ptr;
   logic [1:0]      r_rd_ptr;
   logic [2:0]      r_count;
   logic [1:0]      r_byte_sel;     // byte of the head word being presented
   logic [c_XW-1:0] r_x;
   logic [c_YW-1:0] r_y;
   logic [1:0]      r_age;          // cycles since frame_start, saturating
   logic            r_underflow;

   logic            w_active;
   logic            w_issue;
   logic            w_pix_valid;
   logic            w_xfer;
   logic            w_pop;
   logic            w_eol;
   logic            w_eof;
   logic            w_fifo_wr;
   logic [2:0]      w_outstanding;
   logic [31:0]     w_head;
   logic [7:0]      w_byte;

   assign w_active      = (r_state == S_FETCH) || (r_state == S_DRAIN);
   assign w_pix_valid   = w_active && (r_count != 3'd0);
   assign w_xfer        = w_pix_valid && pix_ready;
   assign w_pop         = w_xfer && (r_byte_sel == 2'd3);
   assign w_eol         = w_pix_valid && (r_x == c_X_LAST);
   assign w_eof         = w_eol && (r_y == c_Y_LAST);
   assign w_outstanding = r_count + {2'b00, r_inflight};
   assign w_head        = r_fifo[r_rd_ptr];
   // The word returning for last cycle's read is dropped by reset or restart.
   assign w_fifo_wr     = r_inflight && resetn && !frame_start;

   always_comb begin
      w_byte = w_head[7:0];
      case (r_byte_sel)
         2'd0:    w_byte = w_head[7:0];
         2'd1:    w_byte = w_head[15:8];
         2'd2:    w_byte = w_head[23:16];
         default: w_byte = w_head[31:24];
      endcase
   end

   // Next state and read issue. Counting the in-flight read as occupied
   // space is what keeps the 4-word FIFO from overflowing.
   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_next = S_IDLE;
         end
         S_FETCH: begin
            w_issue = (w_outstanding < 3'd4) && !frame_start;
            if (w_issue && (r_word_cnt == c_W_LAST)) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pix_ready && w_eof) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      if (frame_start) begin
         w_state_next = S_FETCH;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Word storage carries no reset; occupancy is tracked by r_count.
   always_ff @(posedge CLOCK_50) begin
      if (w_fifo_wr) begin
         r_fifo[r_wr_ptr] <= mem_rdata;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn || frame_start) begin
         r_addr      <= FB_BASE;
         r_word_cnt  <= '0;
         r_inflight  <= 1'b0;
         r_wr_ptr    <= 2'd0;
         r_rd_ptr    <= 2'd0;
         r_count     <= 3'd0;
         r_byte_sel  <= 2'd0;
         r_x         <= '0;
         r_y         <= '0;
         r_age       <= 2'd0;
         r_underflow <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_addr     <= r_addr + 32'd4;
            r_word_cnt <= r_word_cnt + c_W_ONE;
         end

         if (w_fifo_wr) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         case ({w_fifo_wr, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase

         if (w_xfer) begin
            r_byte_sel <= r_byte_sel + 2'd1;
            if (w_eol) begin
               r_x <= '0;
               r_y <= w_eof ? '0 : (r_y + c_Y_ONE);
            end else begin
               r_x <= r_x + c_X_ONE;
            end
         end

         if (r_age != 2'd2) begin
            r_age <= r_age + 2'd1;
         end
         // Starvation only counts once the first word has had time to land;
         // before that an empty FIFO is the normal fetch latency.
         if (pix_ready && !w_pix_valid && w_active && (r_age == 2'd2)) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign mem_addr  = r_addr;
   assign pix_valid = w_pix_valid;
   assign pix_data  = w_pix_valid ? w_byte : 8'h00;
   assign pix_eol   = w_eol;
   assign pix_eof   = w_eof;
   assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_pixel_fetch                                             |
// | Purpose  : Self-checking bench for vga_pixel_fetch. A random framebuffer  |
// |            is served through a one-cycle-latency read port; the expected  |
// |            pixel stream is the framebuffer read byte by byte.             |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vga_pixel_fetch;

   localparam int          H_RES   = 160;
   localparam int          V_RES   = 120;
   localparam logic [31:0] FB_BASE = 32'h0000_1000;
   localparam int          N_PIX   = H_RES * V_RES;
   localparam int          N_WORDS = N_PIX / 4;

   logic        CLOCK_50 = 1'b0;
   logic        resetn;
   logic        frame_start;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        pix_ready;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        pix_eol;
   logic        pix_eof;
   logic        underflow;

   logic [31:0] fb [N_WORDS];
   int tests_run    = 0;
   int tests_failed = 0;

   vga_pixel_fetch #(
      .H_RES   (H_RES),
      .V_RES   (V_RES),
      .FB_BASE (FB_BASE)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .frame_start (frame_start),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .pix_ready   (pix_ready),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_eol     (pix_eol),
      .pix_eof     (pix_eof),
      .underflow   (underflow)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [31:0] fb_read(input logic [31:0] a);
      int idx;
      if (a >= FB_BASE && a < FB_BASE + 32'(4 * N_WORDS)) begin
         idx = int'((a - FB_BASE) >> 2);
         return fb[idx];
      end
      return 32'hDEAD_BEEF;
   endfunction

   // Synchronous read port: data for the address seen at an edge is
   // presented during the following cycle.
   always @(posedge CLOCK_50) mem_rdata <= fb_read(mem_addr);

   // Reference model: pixel k is byte k%4 of word k/4.
   function automatic logic [7:0] exp_byte(input int k);
      logic [31:0] w;
      w = fb[k / 4];
      return w[8 * (k % 4) +: 8];
   endfunction

   function automatic logic exp_eol(input int k);
      return ((k % H_RES) == H_RES - 1);
   endfunction

   function automatic logic exp_eof(input int k);
      return (k == N_PIX - 1);
   endfunction

   task automatic test_reset();
      resetn = 1'b0; frame_start = 1'b1; pix_ready = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      tests_run++;
      if (pix_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, want 0", pix_valid); end
      tests_run++;
      if (pix_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h, want 00", pix_data); end
      tests_run++;
      if (pix_eol !== 1'b0 || pix_eof !== 1'b0) begin tests_failed++; $display("FAIL reset_eol_eof: got %b%b, want 00", pix_eol, pix_eof); end
      tests_run++;
      if (underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_underflow: got %b, want 0", underflow); end
      tests_run++;
      if (mem_addr !== FB_BASE) begin tests_failed++; $display("FAIL reset_addr: got %h, want %h", mem_addr, FB_BASE); end
      resetn = 1'b1; frame_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLOCK_50);
         tests_run++;
         if (pix_valid !== 1'b0 || mem_addr !== FB_BASE) begin
            tests_failed++;
            $display("FAIL reset_idle_hold: valid=%b addr=%h, want valid=0 addr=%h", pix_valid, mem_addr, FB_BASE);
         end
      end
   endtask

   task automatic test_first_pixel();
      int cyc;
      logic [7:0] want [4];
      want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33; want[3] = 8'h44;
      @(negedge CLOCK_50); frame_start = 1'b1; pix_ready = 1'b0;
      @(negedge CLOCK_50); frame_start = 1'b0;
      tests_run++;
      if (mem_addr !== FB_BASE) begin tests_failed++; $display("FAIL first_addr0: got %h, want %h", mem_addr, FB_BASE); end
      @(negedge CLOCK_50);
      tests_run++;
      if (mem_addr !== FB_BASE + 32'd4) begin tests_failed++; $display("FAIL first_addr1: got %h, want %h", mem_addr, FB_BASE + 32'd4); end
      cyc = 2;
      while (pix_valid !== 1'b1 && cyc < 3) begin
         @(negedge CLOCK_50); cyc++;
      end
      tests_run++;
      if (pix_valid !== 1'b1 || pix_data !== 8'h11) begin
         tests_failed++;
         $display("FAIL first_pixel: valid=%b data=%h at cycle %0d, want valid=1 data=11 by cycle 3", pix_valid, pix_data, cyc);
      end
      @(negedge CLOCK_50);
      tests_run++;
      if (pix_valid !== 1'b1 || pix_data !== 8'h11) begin
         tests_failed++;
         $display("FAIL first_stall_hold: valid=%b data=%h, want valid=1 data=11", pix_valid, pix_data);
      end
      pix_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         @(negedge CLOCK_50);
         tests_run++;
         if (pix_valid !== 1'b1 || pix_data !== want[i]) begin
            tests_failed++;
            $display("FAIL first_seq[%0d]: valid=%b data=%h, want valid=1 data=%h", i, pix_valid, pix_data, want[i]);
         end
      end
      pix_ready = 1'b0;
   endtask

   task automatic test_full_frame(input int ready_pct);
      int k, cyc, budget, n_eol, n_eof, eof_at, lfail, issued;
      logic stalled, s_eol, s_eof;
      logic [7:0] s_data;
      logic [31:0] prev_addr;
      k = 0; cyc = 0; n_eol = 0; n_eof = 0; eof_at = -1; lfail = 0;
      stalled = 1'b0; s_eol = 1'b0; s_eof = 1'b0; s_data = 8'h00;
      budget = (N_PIX * 100) / ready_pct + 2000;
      @(negedge CLOCK_50); frame_start = 1'b1; pix_ready = 1'b0;
      @(negedge CLOCK_50); frame_start = 1'b0;
      prev_addr = mem_addr;
      while (k < N_PIX && cyc < budget && lfail < 20) begin
         pix_ready = ($urandom_range(99, 0) < ready_pct);
         if (stalled) begin
            tests_run++;
            if (pix_valid !== 1'b1 || pix_data !== s_data || pix_eol !== s_eol || pix_eof !== s_eof) begin
               tests_failed++; lfail++;
               $display("FAIL stall_hold[%0d]: valid=%b data=%h eol=%b eof=%b, want valid=1 data=%h eol=%b eof=%b",
                        k, pix_valid, pix_data, pix_eol, pix_eof, s_data, s_eol, s_eof);
            end
         end
         if (mem_addr !== prev_addr) begin
            tests_run++;
            if (mem_addr !== prev_addr + 32'd4 || prev_addr > FB_BASE + 32'h4AFC) begin
               tests_failed++; lfail++;
               $display("FAIL addr_step: %h -> %h, want +4 and issued addr <= %h", prev_addr, mem_addr, FB_BASE + 32'h4AFC);
            end
            prev_addr = mem_addr;
         end
         issued = int'((mem_addr - FB_BASE) >> 2);
         tests_run++;
         if (issued - k / 4 > 4) begin
            tests_failed++; lfail++;
            $display("FAIL outstanding: got %0d words, want <= 4", issued - k / 4);
         end
         if (ready_pct == 100 && k > 0) begin
            tests_run++;
            if (pix_valid !== 1'b1) begin
               tests_failed++; lfail++;
               $display("FAIL throughput[%0d]: valid=%b, want 1", k, pix_valid);
            end
         end
         if (pix_valid === 1'b1 && pix_ready) begin
            tests_run++;
            if (pix_data !== exp_byte(k) || pix_eol !== exp_eol(k) || pix_eof !== exp_eof(k)) begin
               tests_failed++; lfail++;
               $display("FAIL pixel[%0d]: data=%h eol=%b eof=%b, want data=%h eol=%b eof=%b",
                        k, pix_data, pix_eol, pix_eof, exp_byte(k), exp_eol(k), exp_eof(k));
            end
            if (pix_eol === 1'b1) n_eol++;
            if (pix_eof === 1'b1) begin n_eof++; eof_at = k + 1; end
            k++;
            stalled = 1'b0;
         end else begin
            stalled = (pix_valid === 1'b1);
            s_data = pix_data; s_eol = pix_eol; s_eof = pix_eof;
         end
         @(negedge CLOCK_50); cyc++;
      end
      tests_run++;
      if (k != N_PIX) begin tests_failed++; $display("FAIL frame_count: got %0d transfers, want %0d", k, N_PIX); end
      tests_run++;
      if (n_eol != V_RES) begin tests_failed++; $display("FAIL frame_eol: got %0d, want %0d", n_eol, V_RES); end
      tests_run++;
      if (n_eof != 1 || eof_at != N_PIX) begin tests_failed++; $display("FAIL frame_eof: got %0d at %0d, want 1 at %0d", n_eof, eof_at, N_PIX); end
      pix_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (pix_valid !== 1'b0) begin tests_failed++; $display("FAIL frame_idle: valid=%b after eof, want 0", pix_valid); end
         @(negedge CLOCK_50);
      end
      tests_run++;
      if (underflow !== 1'b0) begin tests_failed++; $display("FAIL frame_underflow: got %b, want 0", underflow); end
      tests_run++;
      if (mem_addr !== FB_BASE + 32'(4 * N_WORDS)) begin
         tests_failed++; $display("FAIL frame_end_addr: got %h, want %h", mem_addr, FB_BASE + 32'(4 * N_WORDS));
      end
      pix_ready = 1'b0;
   endtask

   task automatic test_restart();
      int k, cyc;
      @(negedge CLOCK_50); frame_start = 1'b1; pix_ready = 1'b0;
      @(negedge CLOCK_50); frame_start = 1'b0;
      k = 0; cyc = 0;
      while (k < 500 && cyc < 5000) begin
         pix_ready = ($urandom_range(99, 0) < 80);
         if (pix_valid === 1'b1 && pix_ready) begin
            tests_run++;
            if (pix_data !== exp_byte(k)) begin tests_failed++; $display("FAIL restart_pre[%0d]: got %h, want %h", k, pix_data, exp_byte(k)); end
            k++;
         end
         @(negedge CLOCK_50); cyc++;
      end
      tests_run++;
      if (k != 500) begin tests_failed++; $display("FAIL restart_prefix: got %0d transfers, want 500", k); end
      frame_start = 1'b1; pix_ready = 1'b0;
      @(negedge CLOCK_50); frame_start = 1'b0;
      tests_run++;
      if (underflow !== 1'b0) begin tests_failed++; $display("FAIL restart_underflow: got %b, want 0", underflow); end
      cyc = 1;
      while (pix_valid !== 1'b1 && cyc < 3) begin
         @(negedge CLOCK_50); cyc++;
      end
      tests_run++;
      if (pix_valid !== 1'b1) begin tests_failed++; $display("FAIL restart_first_valid: valid=%b at cycle %0d, want 1 by cycle 3", pix_valid, cyc); end
      pix_ready = 1'b1; k = 0; cyc = 0;
      while (k < 2 * H_RES && cyc < 1000) begin
         if (pix_valid === 1'b1) begin
            tests_run++;
            if (pix_data !== exp_byte(k) || pix_eol !== exp_eol(k) || pix_eof !== 1'b0) begin
               tests_failed++;
               $display("FAIL restart_pixel[%0d]: data=%h eol=%b eof=%b, want data=%h eol=%b eof=0",
                        k, pix_data, pix_eol, pix_eof, exp_byte(k), exp_eol(k));
            end
            k++;
         end
         @(negedge CLOCK_50); cyc++;
      end
      tests_run++;
      if (k != 2 * H_RES) begin tests_failed++; $display("FAIL restart_count: got %0d, want %0d", k, 2 * H_RES); end
      pix_ready = 1'b0;
   endtask

   task automatic test_underflow();
      @(negedge CLOCK_50); frame_start = 1'b1; pix_ready = 1'b0;
      @(negedge CLOCK_50); frame_start = 1'b0; pix_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tests_run++;
         if (underflow !== 1'b0) begin tests_failed++; $display("FAIL underflow_early[%0d]: got %b, want 0", i, underflow); end
         @(negedge CLOCK_50);
      end
      // Starve the FIFO by blocking returning read data.
      force dut.r_inflight = 1'b0;
      repeat (24) @(negedge CLOCK_50);
      tests_run++;
      if (underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_set: got %b, want 1", underflow); end
      release dut.r_inflight;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLOCK_50);
         tests_run++;
         if (underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_sticky[%0d]: got %b, want 1", i, underflow); end
      end
      frame_start = 1'b1;
      @(negedge CLOCK_50); frame_start = 1'b0;
      tests_run++;
      if (underflow !== 1'b0) begin tests_failed++; $display("FAIL underflow_clear: got %b, want 0", underflow); end
      pix_ready = 1'b0;
   endtask

   task automatic test_drain_reset();
      int cyc;
      @(negedge CLOCK_50); frame_start = 1'b1; pix_ready = 1'b0;
      @(negedge CLOCK_50); frame_start = 1'b0; pix_ready = 1'b1;
      cyc = 0;
      while (mem_addr !== FB_BASE + 32'(4 * N_WORDS) && cyc < N_PIX + 200) begin
         @(negedge CLOCK_50); cyc++;
      end
      tests_run++;
      if (mem_addr !== FB_BASE + 32'(4 * N_WORDS) || pix_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL drain_reach: addr=%h valid=%b, want addr=%h valid=1", mem_addr, pix_valid, FB_BASE + 32'(4 * N_WORDS));
      end
      resetn = 1'b0;
      @(negedge CLOCK_50); resetn = 1'b1;
      tests_run++;
      if (pix_valid !== 1'b0 || pix_data !== 8'h00 || pix_eol !== 1'b0 || pix_eof !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_reset_out: valid=%b data=%h eol=%b eof=%b, want 0 00 0 0", pix_valid, pix_data, pix_eol, pix_eof);
      end
      tests_run++;
      if (underflow !== 1'b0 || mem_addr !== FB_BASE) begin
         tests_failed++;
         $display("FAIL drain_reset_state: underflow=%b addr=%h, want 0 %h", underflow, mem_addr, FB_BASE);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge CLOCK_50);
         tests_run++;
         if (pix_valid !== 1'b0 || mem_addr !== FB_BASE) begin
            tests_failed++;
            $display("FAIL drain_quiet[%0d]: valid=%b addr=%h, want 0 %h", i, pix_valid, mem_addr, FB_BASE);
         end
      end
      pix_ready = 1'b0;
      frame_start = 1'b1;
      @(negedge CLOCK_50); frame_start = 1'b0;
      cyc = 1;
      while (pix_valid !== 1'b1 && cyc < 3) begin
         @(negedge CLOCK_50); cyc++;
      end
      tests_run++;
      if (pix_valid !== 1'b1 || pix_data !== exp_byte(0)) begin
         tests_failed++;
         $display("FAIL drain_recover: valid=%b data=%h, want 1 %h", pix_valid, pix_data, exp_byte(0));
      end
   endtask

   initial begin
      resetn = 1'b0; frame_start = 1'b0; pix_ready = 1'b0;
      for (int i = 0; i < N_WORDS; i++) fb[i] = $urandom;
      fb[0] = 32'h4433_2211;
      test_reset();
      test_first_pixel();
      test_full_frame(100);
      test_full_frame(75);
      test_restart();
      test_underflow();
      test_drain_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #(20 * 200000);
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
